// File: rtl/m92_pkg.sv
// Shared types and constants for the M92 program-ROM fetch path.
package m92_pkg;

  localparam logic [31:0] CPU_ROM_SDR_BASE = 32'h0010_0000;
  localparam int          LINE_TAG_W       = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  function automatic logic [15:0] line_word(input logic [63:0] line, input logic [1:0] sel);
    logic [15:0] w;
    case (sel)
      2'd0:    w = line[15:0];
      2'd1:    w = line[31:16];
      2'd2:    w = line[47:32];
      default: w = line[63:48];
    endcase
    return w;
  endfunction

  // Byte address in SDRAM of the 8-byte line holding a ROM address.
  function automatic logic [31:0] line_byte_addr(input logic [31:0] base,
                                                 input logic [LINE_TAG_W-1:0] line_tag);
    return base + {12'd0, line_tag, 3'd0};
  endfunction

endpackage

// File: rtl/m92_rom_fetch_if.sv
// CPU-side read port and SDRAM-side line fetch port of the ROM fetch block.
interface m92_rom_fetch_if #(
  parameter int SDR_AW = 25
) ();
  logic              cpu_rd;
  logic              cpu_rom_memrq;
  logic [19:0]       rom_addr;
  logic              flush;
  logic [15:0]       cpu_dout;
  logic              cpu_valid;
  logic              cpu_busy;
  logic              sdr_req;
  logic [SDR_AW-1:0] sdr_addr;
  logic              sdr_ack;
  logic [63:0]       sdr_data;

  modport master (
    output cpu_rd, cpu_rom_memrq, rom_addr, flush, sdr_ack, sdr_data,
    input  cpu_dout, cpu_valid, cpu_busy, sdr_req, sdr_addr
  );

  modport slave (
    input  cpu_rd, cpu_rom_memrq, rom_addr, flush, sdr_ack, sdr_data,
    output cpu_dout, cpu_valid, cpu_busy, sdr_req, sdr_addr
  );
endinterface

// File: rtl/m92_rom_line.sv
// Single-line ROM buffer: 64-bit data, 17-bit tag, valid bit. Flush beats load.
module m92_rom_line
  import m92_pkg::*;
(
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  load,
  input  logic                  load_valid,
  input  logic [LINE_TAG_W-1:0] load_tag,
  input  logic [63:0]           load_data,
  output logic                  valid,
  output logic [LINE_TAG_W-1:0] tag,
  output logic [63:0]           data
);

  logic                  valid_q, valid_d;
  logic [LINE_TAG_W-1:0] tag_q, tag_d;
  logic [63:0]           data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (load) begin
      valid_d = load_valid;
      tag_d   = load_tag;
      data_d  = load_data;
    end
    if (flush) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign tag   = tag_q;
  assign data  = data_q;

endmodule

// File: rtl/m92_rom_fetch.sv
// CPU program-ROM word fetch through a one-line SDRAM buffer.
// Hit returns in 1 cycle; miss returns the cycle after sdr_ack. Busy while not idle.
module m92_rom_fetch
  import m92_pkg::*;
#(
  parameter int          SDR_AW   = 25,
  parameter logic [31:0] ROM_BASE = CPU_ROM_SDR_BASE
) (
  input logic            clk_sys,
  input logic            reset_n,
  m92_rom_fetch_if.slave bus
);

  fetch_state_t      state_q, state_d;
  logic [19:1]       addr_q, addr_d;
  logic [15:0]       cpu_dout_q, cpu_dout_d;
  logic              cpu_valid_q, cpu_valid_d;
  logic              sdr_req_q, sdr_req_d;
  logic [SDR_AW-1:0] sdr_addr_q, sdr_addr_d;
  logic              flushed_q, flushed_d;
  logic              arm_q, arm_d;

  logic                  line_valid;
  logic [LINE_TAG_W-1:0] line_tag;
  logic [63:0]           line_data;
  logic                  line_load;
  logic                  line_load_valid;

  logic        accept;
  logic        hit;
  logic [31:0] byte_addr;
  logic        unused_ok;

  m92_rom_line u_line (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .flush      (bus.flush),
    .load       (line_load),
    .load_valid (line_load_valid),
    .load_tag   (addr_q[19:3]),
    .load_data  (bus.sdr_data),
    .valid      (line_valid),
    .tag        (line_tag),
    .data       (line_data)
  );

  // arm_q holds off acceptance until the second edge after reset release.
  assign accept    = bus.cpu_rd && bus.cpu_rom_memrq && (state_q == IDLE) && arm_q;
  assign hit       = line_valid && (line_tag == bus.rom_addr[19:3]) && !bus.flush;
  assign byte_addr = line_byte_addr(ROM_BASE, bus.rom_addr[19:3]);
  assign unused_ok = ^{bus.rom_addr[0], byte_addr};
  assign arm_d     = 1'b1;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cpu_dout_d      = cpu_dout_q;
    cpu_valid_d     = 1'b0;
    sdr_req_d       = sdr_req_q;
    sdr_addr_d      = sdr_addr_q;
    flushed_d       = flushed_q;
    line_load       = 1'b0;
    line_load_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d    = bus.rom_addr[19:1];
          flushed_d = 1'b0;
          if (hit) begin
            state_d     = RESP;
            cpu_valid_d = 1'b1;
            cpu_dout_d  = line_word(line_data, bus.rom_addr[2:1]);
          end else begin
            state_d    = FILL;
            sdr_req_d  = 1'b1;
            sdr_addr_d = byte_addr[SDR_AW:1];
          end
        end
      end
      FILL: begin
        if (bus.flush) begin
          flushed_d = 1'b1;
        end
        if (bus.sdr_ack) begin
          // A flush seen at any point of the fill delivers the word but leaves the line invalid.
          state_d         = RESP;
          sdr_req_d       = 1'b0;
          line_load       = 1'b1;
          line_load_valid = !flushed_q;
          cpu_valid_d     = 1'b1;
          cpu_dout_d      = line_word(bus.sdr_data, addr_q[2:1]);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cpu_dout_q  <= '0;
      cpu_valid_q <= 1'b0;
      sdr_req_q   <= 1'b0;
      sdr_addr_q  <= '0;
      flushed_q   <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_valid_q <= cpu_valid_d;
      sdr_req_q   <= sdr_req_d;
      sdr_addr_q  <= sdr_addr_d;
      flushed_q   <= flushed_d;
      arm_q       <= arm_d;
    end
  end

  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.cpu_valid = cpu_valid_q;
  assign bus.cpu_busy  = (state_q != IDLE);
  assign bus.sdr_req   = sdr_req_q;
  assign bus.sdr_addr  = sdr_addr_q;

endmodule

// File: doc/m92_rom_fetch.md
M92_ROM_FETCH -- requirements
Module: m92_rom_fetch

Interface
REQ-001 Parameter SDR_AW, default 25: SDRAM word-address width.
REQ-002 Parameter ROM_BASE, default CPU_ROM_SDR_BASE (from m92_pkg): SDRAM byte offset of the CPU program ROM.
REQ-003 clk_sys  in  1  system clock; the only clock; all logic on the rising edge.
REQ-004 reset_n  in  1  reset; asynchronous assert, active-low.
REQ-005 cpu_rd  in  1  one-cycle read strobe, qualified by cpu_rom_memrq.
REQ-006 cpu_rom_memrq  in  1  the decoded address falls in program ROM.
REQ-007 rom_addr  in  20  translated ROM byte address, already banked.
REQ-008 flush  in  1  one-cycle pulse on a bank_select write; invalidates the line buffer.
REQ-009 cpu_dout  out  16  returned ROM word.
REQ-010 cpu_valid  out  1  one-cycle pulse; cpu_dout is valid in that cycle.
REQ-011 cpu_busy  out  1  high from an accepted access until its cpu_valid cycle, inclusive.
REQ-012 sdr_req  out  1  level request to SDRAM; held until sdr_ack.
REQ-013 sdr_addr  out  SDR_AW  SDRAM address of an 8-byte line, 8-byte aligned.
REQ-014 sdr_ack  in  1  one-cycle pulse; sdr_data is valid in that cycle.
REQ-015 sdr_data  in  64  burst line data; word 0 occupies bits [15:0].

Function
REQ-016 The block SHALL hold a single 64-bit line buffer with a 17-bit tag (rom_addr[19:3]) and a valid bit.
REQ-017 State machine SHALL use states IDLE, FILL and RESP.
- IDLE->RESP on an accepted hit.
- IDLE->FILL on an accepted miss.
- FILL->RESP on sdr_ack.
- RESP->IDLE unconditionally.
REQ-018 An access is accepted when cpu_rd=1, cpu_rom_memrq=1 and state=IDLE. The block latches rom_addr[19:1] at acceptance.
REQ-019 cpu_rd with cpu_rom_memrq=0 SHALL be ignored, with no state change.
REQ-020 cpu_rd while not in IDLE SHALL be ignored. cpu_busy stays high and the in-flight access completes unaffected.
REQ-021 Hit: valid=1 and tag equal. cpu_valid SHALL pulse in the cycle after acceptance (latency 1), with cpu_dout = buffer word rom_addr[2:1].
REQ-022 Miss: sdr_req SHALL rise in the cycle after acceptance, with sdr_addr = (ROM_BASE + {rom_addr[19:3],3'b000}) >> 1, truncated to SDR_AW.
REQ-023 sdr_req and sdr_addr SHALL stay stable until the cycle sdr_ack is sampled high. sdr_req drops in the following cycle.
REQ-024 On sdr_ack the block SHALL:
- load sdr_data into the buffer;
- set the tag;
- set valid=1, unless a flush occurred during FILL;
- pulse cpu_valid in the next cycle with the selected word.
Miss latency = sdr_ack cycle + 1.
REQ-025 sdr_ack outside FILL SHALL be ignored.
REQ-026 flush SHALL clear valid at the next edge.
- A flush in the same cycle as an accepted cpu_rd forces a miss.
- A flush during FILL still returns the fetched word to the CPU, but leaves valid=0.
REQ-027 rom_addr[0] SHALL be ignored, because all accesses are word accesses.
REQ-028 cpu_dout SHALL hold its last value outside cpu_valid cycles.

Reset
REQ-029 While reset_n=0, the block SHALL force: state=IDLE, valid=0, tag=0, buffer=0, cpu_dout=0, cpu_valid=0, cpu_busy=0, sdr_req=0, sdr_addr=0.
REQ-030 Reset asserted mid-FILL SHALL drop sdr_req immediately. A later stale sdr_ack SHALL be ignored per REQ-025.
REQ-031 Release SHALL be synchronous-safe: the first access is accepted no earlier than the second edge after reset_n rises.

Structure
REQ-032 CPU_ROM_SDR_BASE and the fetch_state_t enum SHALL live in m92_pkg.
REQ-033 The line buffer, tag and valid bit MAY be a sub-module named m92_rom_line. The FSM stays in m92_rom_fetch.

Verification
REQ-034 Cold miss: rom_addr=0x00010 and rd. Required: sdr_req=1 with sdr_addr=(ROM_BASE+0x10)>>1. Ack 5 cycles later with sdr_data=0x4444_3333_2222_1111. Required: cpu_valid one cycle after ack, cpu_dout=0x1111.
REQ-035 Hit: read 0x00016 immediately after REQ-034. Required: no sdr_req, cpu_valid at +1, cpu_dout=0x4444.
REQ-036 Flush: flush pulse, then read 0x00012. Required: a new sdr_req to the same line. The same flush coincident with a rd also forces a miss.
REQ-037 Flush mid-FILL: flush between req and ack. Required: the word is delivered, then a re-read of the same address misses.
REQ-038 Reset mid-FILL: reset_n low 2 cycles during FILL, then a spurious sdr_ack. Required: sdr_req=0, no cpu_valid, cpu_busy=0.
REQ-039 Overlap/ignore: rd while busy, and rd with cpu_rom_memrq=0. Required: no extra cpu_valid and no extra sdr_req.
